// File: rtl/hpdcache_sram_arb_pkg.sv
// Shared types for the HPDcache SRAM port arbiter: FSM state encoding and
// the index-width helper used by the round-robin arbiter.
package hpdcache_sram_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    INIT = 1'b1
  } arb_state_e;

  // Index width for an N-way selector; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/hpdcache_rr_arbiter.sv
// Per-cycle round-robin arbiter: picks the first request at or after the
// rotating pointer, and moves the pointer past the winner on every grant.
module hpdcache_rr_arbiter
  import hpdcache_sram_arb_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] ptr_n_s;
  logic [IW-1:0] lo_idx_s;
  logic [IW-1:0] hi_idx_s;
  logic          lo_any_s;
  logic          hi_any_s;
  logic          any_s;

  // Grant selection: lowest request at/after the pointer, else lowest overall (wrap).
  always_comb begin
    lo_any_s = 1'b0;
    lo_idx_s = {IW{1'b0}};
    hi_any_s = 1'b0;
    hi_idx_s = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      lo_any_s = lo_any_s | req[k];
      lo_idx_s = req[k] ? IW'(k) : lo_idx_s;
      hi_any_s = hi_any_s | (req[k] & (k >= int'(ptr_r)));
      hi_idx_s = (req[k] && (k >= int'(ptr_r))) ? IW'(k) : hi_idx_s;
    end
    any_s   = en & lo_any_s;
    gnt_idx = hi_any_s ? hi_idx_s : lo_idx_s;
    for (int k = 0; k < N; k++) begin
      gnt[k] = any_s & (gnt_idx == IW'(k));
    end
    if (any_s) begin
      ptr_n_s = (gnt_idx == IW'(N - 1)) ? {IW{1'b0}} : gnt_idx + IW'(1);
    end else begin
      ptr_n_s = ptr_r;
    end
  end

  // Rotating priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {IW{1'b0}};
    end else begin
      ptr_r <= ptr_n_s;
    end
  end

endmodule

// File: rtl/hpdcache_sram_arbiter.sv
// Shares one single-port cache SRAM between NREQ requesters with round-robin
// arbitration and a zero-fill sweep. Define HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
// to start the sweep automatically when reset is released.
module hpdcache_sram_arbiter
  import hpdcache_sram_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned ADDR_SIZE = 8,
  parameter int unsigned DATA_SIZE = 64,
  parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_i,
  output logic                      init_busy_o,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ-1:0]           req_we_i,
  input  logic [NREQ*ADDR_SIZE-1:0] req_addr_i,
  input  logic [NREQ*DATA_SIZE-1:0] req_wdata_i,
  output logic [NREQ-1:0]           rsp_valid_o,
  output logic [DATA_SIZE-1:0]      rsp_rdata_o,
  output logic                      sram_cs_o,
  output logic                      sram_we_o,
  output logic [ADDR_SIZE-1:0]      sram_addr_o,
  output logic [DATA_SIZE-1:0]      sram_wdata_o,
  input  logic [DATA_SIZE-1:0]      sram_rdata_i
);

  localparam int unsigned IW = idx_width(NREQ);
  // One extra bit so a full 2**ADDR_SIZE sweep reaches its last index without wrapping.
  localparam int unsigned CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] LAST_ADDR = CW'(DEPTH - 1);

`ifdef HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
  localparam arb_state_e RST_STATE = INIT;
`else
  localparam arb_state_e RST_STATE = ARB;
`endif

  arb_state_e      state_r;
  arb_state_e      state_n_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_n_s;
  logic [NREQ-1:0] gnt_s;
  logic [IW-1:0]   gnt_idx_s;
  logic            arb_en_s;
  logic            win_we_s;
  logic [NREQ-1:0] rsp_valid_r;

  // Requests are only served in ARB and never while reset is asserted.
  assign arb_en_s = rst_n & (state_r == ARB);

  hpdcache_rr_arbiter #(
    .N (NREQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid_i),
    .en      (arb_en_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  assign win_we_s    = req_we_i[gnt_idx_s];
  assign req_ready_o = gnt_s;
  assign init_busy_o = (state_r == INIT);
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_rdata_o = sram_rdata_i;

  // Next-state and sweep-counter logic.
  always_comb begin
    state_n_s = state_r;
    cnt_n_s   = cnt_r;
    case (state_r)
      ARB: begin
        if (init_i) begin
          state_n_s = INIT;
          cnt_n_s   = {CW{1'b0}};
        end else begin
          state_n_s = ARB;
          cnt_n_s   = cnt_r;
        end
      end
      INIT: begin
        if (cnt_r == LAST_ADDR) begin
          state_n_s = ARB;
          cnt_n_s   = {CW{1'b0}};
        end else begin
          state_n_s = INIT;
          cnt_n_s   = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n_s = ARB;
        cnt_n_s   = {CW{1'b0}};
      end
    endcase
  end

  // SRAM port mux: the sweep owns the port in INIT, the arbiter winner in ARB.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = {ADDR_SIZE{1'b0}};
    sram_wdata_o = {DATA_SIZE{1'b0}};
    case (state_r)
      ARB: begin
        if (|gnt_s) begin
          sram_cs_o    = 1'b1;
          sram_we_o    = win_we_s;
          sram_addr_o  = req_addr_i[gnt_idx_s*ADDR_SIZE +: ADDR_SIZE];
          sram_wdata_o = req_wdata_i[gnt_idx_s*DATA_SIZE +: DATA_SIZE];
        end else begin
          sram_cs_o    = 1'b0;
        end
      end
      INIT: begin
        sram_cs_o    = rst_n;
        sram_we_o    = 1'b1;
        sram_addr_o  = cnt_r[ADDR_SIZE-1:0];
        sram_wdata_o = {DATA_SIZE{1'b0}};
      end
      default: begin
        sram_cs_o    = 1'b0;
      end
    endcase
  end

  // State, sweep counter and one-cycle-delayed read-grant flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RST_STATE;
      cnt_r       <= {CW{1'b0}};
      rsp_valid_r <= {NREQ{1'b0}};
    end else begin
      state_r     <= state_n_s;
      cnt_r       <= cnt_n_s;
      rsp_valid_r <= gnt_s & {NREQ{~win_we_s}};
    end
  end

endmodule

// File: tb/tb_hpdcache_sram_arbiter.sv
// Directed bench for hpdcache_sram_arbiter with a behavioural SRAM and a
// response scoreboard (reads push expected data, responses pop and compare).
module tb_hpdcache_sram_arbiter;

  localparam int NREQ  = 2;
  localparam int AS    = 8;
  localparam int DS    = 64;
  localparam int DEPTH = 256;

`ifdef HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
  localparam logic RST_BUSY = 1'b1;
`else
  localparam logic RST_BUSY = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 init_i;
  logic                 init_busy;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*AS-1:0]   req_addr;
  logic [NREQ*DS-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DS-1:0]        rsp_rdata;
  logic                 sram_cs;
  logic                 sram_we;
  logic [AS-1:0]        sram_addr;
  logic [DS-1:0]        sram_wdata;
  logic [DS-1:0]        sram_rdata;

  logic [AS-1:0]        drv_addr  [NREQ];
  logic [DS-1:0]        drv_wdata [NREQ];
  logic [DS-1:0]        mem       [DEPTH];
  logic [DS-1:0]        exp_mem   [DEPTH];
  logic                 preload;

  typedef struct {
    int          due;
    logic [1:0]  mask;
    logic [63:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  assign req_addr  = {drv_addr[1], drv_addr[0]};
  assign req_wdata = {drv_wdata[1], drv_wdata[0]};

  hpdcache_sram_arbiter #(
    .NREQ      (NREQ),
    .ADDR_SIZE (AS),
    .DATA_SIZE (DS),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init_i       (init_i),
    .init_busy_o  (init_busy),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_rdata_o  (rsp_rdata),
    .sram_cs_o    (sram_cs),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  function automatic logic [63:0] pat(input int i);
    return (i == 5) ? 64'h0000_0000_0000_00A5 : (64'hC0DE_0000_0000_0000 | 64'(i));
  endfunction

  // Single-port SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (sram_cs) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [7:0] a0, input logic [7:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1);
    req_valid    = v;
    req_we       = we;
    drv_addr[0]  = a0;
    drv_addr[1]  = a1;
    drv_wdata[0] = d0;
    drv_wdata[1] = d1;
  endtask

  // One clock cycle: check comb outputs at negedge against the expected grant /
  // sweep index, update the reference memory, and service the response queue.
  task automatic step(input string tag, input logic [1:0] exp_rdy,
                      input logic exp_busy, input int sweep_idx);
    int   k;
    rsp_t e;
    @(negedge clk);
    chk({tag, "/ready"}, 64'(req_ready), 64'(exp_rdy));
    chk({tag, "/busy"}, 64'(init_busy), 64'(exp_busy));
    if (sweep_idx >= 0) begin
      chk({tag, "/cs"}, 64'(sram_cs), 64'd1);
      chk({tag, "/we"}, 64'(sram_we), 64'd1);
      chk({tag, "/addr"}, 64'(sram_addr), 64'(sweep_idx));
      chk({tag, "/wdata"}, sram_wdata, 64'd0);
      exp_mem[sweep_idx] = 64'd0;
    end else if (exp_rdy != 2'b00) begin
      k = exp_rdy[1] ? 1 : 0;
      chk({tag, "/cs"}, 64'(sram_cs), 64'd1);
      chk({tag, "/we"}, 64'(sram_we), 64'(req_we[k]));
      chk({tag, "/addr"}, 64'(sram_addr), 64'(drv_addr[k]));
      if (req_we[k]) begin
        chk({tag, "/wdata"}, sram_wdata, drv_wdata[k]);
        exp_mem[drv_addr[k]] = drv_wdata[k];
      end else begin
        e.due  = cyc + 1;
        e.mask = exp_rdy;
        e.data = exp_mem[drv_addr[k]];
        exp_q.push_back(e);
      end
    end else begin
      chk({tag, "/cs"}, 64'(sram_cs), 64'd0);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'(e.mask));
      chk({tag, "/rsp_rdata"}, rsp_rdata, e.data);
    end else begin
      chk({tag, "/rsp_valid"}, 64'(rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic auto_sweep();
    for (int i = 0; i < DEPTH; i++) step("auto_sweep", 2'b00, 1'b1, i);
  endtask

  initial begin
    rst_n   = 1'b0;
    preload = 1'b1;
    init_i  = 1'b0;
    drive(2'b11, 2'b00, 8'd1, 8'd2, 64'd0, 64'd0);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
    @(posedge clk);
    @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset: requests pending but nothing granted, no SRAM access
    step("reset", 2'b00, RST_BUSY, -1);
    rst_n = 1'b1;
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
`ifdef HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
    auto_sweep();
`endif

    // Lone read of addr 5, then a lone read from requester 1
    drive(2'b01, 2'b00, 8'd5, 8'd0, 64'd0, 64'd0);
    step("rd0", 2'b01, 1'b0, -1);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    step("rd0_rsp", 2'b00, 1'b0, -1);
    drive(2'b10, 2'b00, 8'd0, 8'd7, 64'd0, 64'd0);
    step("rd1", 2'b10, 1'b0, -1);

    // Contention with pointer at 0: grants 0,1,0,1; req1's write to addr 3 is read back
    drive(2'b11, 2'b10, 8'd10, 8'd3, 64'd0, 64'h1234_5678_9ABC_DEF0);
    step("rr0", 2'b01, 1'b0, -1);
    drive(2'b11, 2'b10, 8'd3, 8'd3, 64'd0, 64'h1234_5678_9ABC_DEF0);
    step("rr1", 2'b10, 1'b0, -1);
    drive(2'b11, 2'b00, 8'd3, 8'd3, 64'd0, 64'd0);
    step("rr2", 2'b01, 1'b0, -1);
    drive(2'b10, 2'b00, 8'd3, 8'd3, 64'd0, 64'd0);
    step("rr3", 2'b10, 1'b0, -1);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    step("idle", 2'b00, 1'b0, -1);

    // init_i together with a read grant; response lands on first INIT cycle
    drive(2'b01, 2'b00, 8'd5, 8'd0, 64'd0, 64'd0);
    init_i = 1'b1;
    step("init_gnt", 2'b01, 1'b0, -1);
    drive(2'b01, 2'b00, 8'd255, 8'd0, 64'd0, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      init_i = (i == 50) ? 1'b1 : 1'b0;
      step("sweep", 2'b00, 1'b1, i);
    end
    init_i = 1'b0;
    step("post_sweep", 2'b01, 1'b0, -1);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    step("post_rsp", 2'b00, 1'b0, -1);

    // Marker write beyond where the next sweep is aborted
    drive(2'b10, 2'b10, 8'd0, 8'd150, 64'd0, 64'h0000_0000_0000_BEEF);
    step("wr150", 2'b10, 1'b0, -1);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    init_i = 1'b1;
    step("init2", 2'b00, 1'b0, -1);
    init_i = 1'b0;
    drive(2'b01, 2'b00, 8'd150, 8'd0, 64'd0, 64'd0);
    for (int i = 0; i < 100; i++) step("sweep2", 2'b00, 1'b1, i);

    // Reset mid-sweep at addr 100: outputs drop immediately
    @(negedge clk);
    chk("abort/addr", 64'(sram_addr), 64'd100);
    rst_n = 1'b0;
    #1;
    chk("abort/busy", 64'(init_busy), 64'(RST_BUSY));
    chk("abort/cs", 64'(sram_cs), 64'd0);
    chk("abort/ready", 64'(req_ready), 64'd0);
    chk("abort/rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
`ifdef HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    auto_sweep();
`endif

    // Pointer back at 0 after reset; addr 150 untouched by the aborted sweep
    drive(2'b11, 2'b00, 8'd150, 8'd150, 64'd0, 64'd0);
    step("ptr0", 2'b01, 1'b0, -1);
    drive(2'b10, 2'b00, 8'd150, 8'd150, 64'd0, 64'd0);
    step("ptr1", 2'b10, 1'b0, -1);
    drive(2'b00, 2'b00, 8'd0, 8'd0, 64'd0, 64'd0);
    step("end", 2'b00, 1'b0, -1);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/hpdcache_sram_arbiter.md
Name: hpdcache_sram_arbiter

Overview:
Shares one single-port cache SRAM macro (the hpdcache_sram wrapper: cs/we/addr/wdata/rdata, 1-cycle read latency) between NREQ requesters.
- Per-cycle round-robin arbitration; routes read data back to the winning requester one cycle later.
- Provides an init sequencer that zero-fills the whole array (used at boot and on cache invalidate-all).
- Sits between the HPDcache controller pipeline / refill / flush units and each data or directory SRAM instance.

Parameters:
NREQ, 2, number of requesters (>=1).
ADDR_SIZE, 8, SRAM address width.
DATA_SIZE, 64, SRAM word width.
DEPTH, 2**ADDR_SIZE, number of words; may be non-power-of-2, must be <= 2**ADDR_SIZE.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
init_i  in  1  pulse: start zero-fill sweep.
init_busy_o  out  1  sweep in progress.
req_valid_i  in  NREQ  request valid per requester.
req_ready_o  out  NREQ  request granted this cycle.
req_we_i  in  NREQ  1 = write, 0 = read.
req_addr_i  in  NREQ*ADDR_SIZE  packed addresses; requester k at bits [k*ADDR_SIZE +: ADDR_SIZE].
req_wdata_i  in  NREQ*DATA_SIZE  packed write data.
rsp_valid_o  out  NREQ  read data valid for requester k.
rsp_rdata_o  out  DATA_SIZE  read data, shared by all requesters.
sram_cs_o, sram_we_o  out  1 each  to SRAM.
sram_addr_o  out  ADDR_SIZE  to SRAM.
sram_wdata_o  out  DATA_SIZE  to SRAM.
sram_rdata_i  in  DATA_SIZE  from SRAM.

Behaviour:
- FSM ARB / INIT. Reset values:
  - state = ARB; rr pointer = 0; init counter = 0; rsp_valid_o = 0; init_busy_o = 0.
  - Combinational outputs: req_ready_o = 0 and sram_cs_o = 0 in reset.
- ARB:
  - Grant = first valid requester at or after the rr pointer (wrapping).
  - req_ready_o is one-hot on the grant, or 0 if no requester is valid; it may depend combinationally on req_valid_i.
  - On grant: sram_cs_o = 1; sram_we_o, sram_addr_o and sram_wdata_o muxed from the winner. Pointer <= grant+1 mod NREQ.
  - When idle: sram_cs_o = 0 and the pointer holds.
- Handshake: a requester holds valid and its payload stable until ready. Transfer = valid & ready. No combinational path from ready back into valid is allowed.
- Read response:
  - Registered grant-read flag. rsp_valid_o[k] = 1 exactly one cycle after a read was granted to k.
  - rsp_rdata_o = sram_rdata_i, pass-through and unregistered.
  - Writes produce no response. One response maximum per cycle; back-to-back reads give back-to-back responses.
- init_i in ARB:
  - Next state INIT; counter <= 0. A grant in the same cycle still completes, and its response is delivered.
- INIT:
  - req_ready_o = 0; init_busy_o = 1; sram_cs_o = 1, sram_we_o = 1, sram_addr_o = counter, sram_wdata_o = 0.
  - Counter increments by 1 each cycle. After writing DEPTH-1, return to ARB; init_busy_o falls the following cycle. Sweep takes exactly DEPTH cycles.
  - init_i while in INIT is ignored; the sweep does not restart.
  - A response pending from the final ARB cycle is still delivered on the first INIT cycle.
- Counter width is ADDR_SIZE+1, so DEPTH = 2**ADDR_SIZE does not wrap before the compare.
- Asserting rst_n low mid-sweep aborts it immediately and returns all state to the reset values.
- NREQ = 1: arbiter degenerates to ready = valid in ARB.

Optional Feature:
HPDCACHE_SRAM_ARB_INIT_ON_RESET_EN
- Defined: reset state is INIT with counter = 0, so the sweep starts automatically on the first cycle after rst_n deasserts. init_busy_o reset value is 1.
- Undefined: reset state is ARB; the sweep runs only on init_i.

Decomposition:
- Package hpdcache_sram_arb_pkg holds the state enum typedef (ARB, INIT).
- Sub-module hpdcache_rr_arbiter, parameterised by N:
  - Inputs: req vector, enable.
  - Outputs: one-hot grant, grant index.
  - Internal rotating pointer.
- Top-level logic: FSM, init counter, muxes, response flag.
- Integration: one instance per SRAM macro.

Test Plan:
- Req0 read addr 5 alone, SRAM preloaded 5=0xA5 -> ready0 same cycle; rsp_valid_o=01 next cycle with rdata 0xA5.
- Both requesters valid continuously for 4 cycles, pointer 0 -> grants 0,1,0,1; the write from req1 to addr 3 is visible in a later read.
- init_i with DEPTH=256 -> init_busy_o high for 256 cycles; sram_addr_o runs 0..255 with we=1 and wdata=0; no ready during the sweep; read of addr 255 afterward returns 0.
- init_i in the same cycle as a req0 read grant -> the read completes and its response arrives on the first INIT cycle; INIT then starts.
- rst_n asserted low at sweep addr 100 -> outputs immediately at reset values; after release, ARB state and a normal grant.
- Macro defined: release reset -> sweep starts with no init_i, init_busy_o = 1 from reset.
